// File: rtl/rp_diag_if.sv
// Diagnostic read-path bus for rp_diag_seq: drive controls, serial diagnostic
// strobes and the registered field/status outputs.
interface rp_diag_if;
  // No valid/ready handshake here: rpDCLK/rpDIND/rpDSCK are free-running
  // levels whose rising edges the slave detects; outputs are plain status levels.
  logic rpDRVCLR;
  logic rpDMD;
  logic rpDCLK;
  logic rpDIND;
  logic rpDSCK;
  logic rpDRDD;
  logic rpZD;
  logic rpSBD;
  logic rpDFE;
  logic rpECE;
  logic rpDWRD;
  logic rpFMTERR;

  modport master (
    output rpDRVCLR, rpDMD, rpDCLK, rpDIND, rpDSCK, rpDRDD,
    input  rpZD, rpSBD, rpDFE, rpECE, rpDWRD, rpFMTERR
  );

  modport slave (
    input  rpDRVCLR, rpDMD, rpDCLK, rpDIND, rpDSCK, rpDRDD,
    output rpZD, rpSBD, rpDFE, rpECE, rpDWRD, rpFMTERR
  );
endinterface

// File: rtl/rp_diag_seq.sv
// Diagnostic sector sequencer: preamble zero detect, sync, data and ECC field envelopes.
// Optional macro RPDIAG_ECC_EN enables the ECC field; without it DATA ends directly in DONE.
module rp_diag_seq #(
    parameter int DATABITS = 4608,
    parameter int ECCBITS  = 32,
    parameter int ZEROBITS = 16
) (
    input  logic       clk,
    input  logic       rst,
    rp_diag_if.slave   bus,
    output logic [2:0] dbgState
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        DATA = 3'd2,
        ECC  = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [12:0] ZERO_MAX  = 13'(ZEROBITS);
    localparam logic [12:0] DATA_LAST = 13'(DATABITS - 1);
`ifdef RPDIAG_ECC_EN
    localparam logic [12:0] ECC_LAST  = 13'(ECCBITS - 1);
`endif

    state_t      state;
    logic [12:0] cnt;
    logic        dclkQ, dclkP, dindQ, dindP, dsckQ, dsckP;
    logic        zd, sbd, dfe, dwrd, fmterr;
`ifdef RPDIAG_ECC_EN
    logic        ece;
`endif
    logic        bitEdge, syncEdge;

    assign bitEdge  = dclkQ & ~dclkP;
    assign syncEdge = (dindQ & ~dindP) | (dsckQ & ~dsckP);

    always_ff @(posedge clk) begin
        if (!rst || bus.rpDRVCLR) begin
            state  <= IDLE;
            cnt    <= '0;
            dclkQ  <= 1'b0;
            dclkP  <= 1'b0;
            dindQ  <= 1'b0;
            dindP  <= 1'b0;
            dsckQ  <= 1'b0;
            dsckP  <= 1'b0;
            zd     <= 1'b0;
            sbd    <= 1'b0;
            dfe    <= 1'b0;
            dwrd   <= 1'b0;
            fmterr <= 1'b0;
`ifdef RPDIAG_ECC_EN
            ece    <= 1'b0;
`endif
        end else begin
            dclkQ <= bus.rpDCLK;
            dclkP <= dclkQ;
            dindQ <= bus.rpDIND;
            dindP <= dindQ;
            dsckQ <= bus.rpDSCK;
            dsckP <= dsckQ;
            if (!bus.rpDMD) begin
                state <= IDLE;
                cnt   <= '0;
                zd    <= 1'b0;
                sbd   <= 1'b0;
                dfe   <= 1'b0;
                dwrd  <= 1'b0;
`ifdef RPDIAG_ECC_EN
                ece   <= 1'b0;
`endif
            end else if (syncEdge) begin
                // Index/sector edge wins over a coincident bit edge; that bit is dropped.
                if (state == DATA || state == ECC) fmterr <= 1'b1;
                state <= PRE;
                cnt   <= '0;
                zd    <= 1'b0;
                sbd   <= 1'b0;
                dfe   <= 1'b0;
                dwrd  <= 1'b0;
`ifdef RPDIAG_ECC_EN
                ece   <= 1'b0;
`endif
            end else if (bitEdge) begin
                dwrd <= 1'b0;
                case (state)
                    PRE: begin
                        if (!bus.rpDRDD) begin
                            if (cnt < ZERO_MAX) cnt <= cnt + 13'd1;
                            zd <= (cnt >= ZERO_MAX - 13'd1);
                        end else if (cnt == ZERO_MAX) begin
                            state <= DATA;
                            cnt   <= '0;
                            zd    <= 1'b0;
                            sbd   <= 1'b1;
                            dfe   <= 1'b1;
                        end else begin
                            cnt <= '0;
                            zd  <= 1'b0;
                        end
                    end
                    DATA: begin
                        cnt  <= cnt + 13'd1;
                        dwrd <= (cnt[3:0] == 4'hF);
                        if (cnt == DATA_LAST) begin
                            cnt <= '0;
                            dfe <= 1'b0;
`ifdef RPDIAG_ECC_EN
                            state <= ECC;
                            ece   <= 1'b1;
`else
                            state <= DONE;
                            sbd   <= 1'b0;
`endif
                        end
                    end
`ifdef RPDIAG_ECC_EN
                    ECC: begin
                        cnt <= cnt + 13'd1;
                        if (cnt == ECC_LAST) begin
                            state <= DONE;
                            cnt   <= '0;
                            ece   <= 1'b0;
                            sbd   <= 1'b0;
                        end
                    end
`endif
                    IDLE, DONE: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rpZD     = zd;
    assign bus.rpSBD    = sbd;
    assign bus.rpDFE    = dfe;
    assign bus.rpDWRD   = dwrd;
    assign bus.rpFMTERR = fmterr;
`ifdef RPDIAG_ECC_EN
    assign bus.rpECE    = ece;
`else
    assign bus.rpECE    = 1'b0;
`endif
    assign dbgState     = state;

endmodule

// File: tb/tb_rp_diag_seq.sv
// Bench for rp_diag_seq: random sector traffic against a field-level model,
// with a change-driven monitor popping expected output vectors from a queue.
module tb_rp_diag_seq;
  localparam int DATABITS = 4608;
  localparam int ECCBITS  = 32;
  localparam int ZEROBITS = 16;
`ifdef RPDIAG_ECC_EN
  localparam bit ECC_EN = 1'b1;
`else
  localparam bit ECC_EN = 1'b0;
`endif

  localparam int P_IDLE = 0, P_PRE = 1, P_DATA = 2, P_ECC = 3, P_DONE = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] dbgState;

  rp_diag_if bus ();

  always #5 clk = ~clk;

  rp_diag_seq #(.DATABITS(DATABITS), .ECCBITS(ECCBITS), .ZEROBITS(ZEROBITS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbgState(dbgState)
  );

  int checks = 0;
  int failures = 0;
  logic [5:0] exp_q[$];

  // Field-level reference: phase, preamble zero run, bit position, sticky error.
  int   mPhase = P_IDLE;
  int   mZeros = 0;
  int   mBits = 0;
  bit   mWord = 1'b0;
  bit   mErr = 1'b0;
  bit   mDmd = 1'b0;
  logic [5:0] mLast = 6'b0;

  // vector order: {zd, sbd, dfe, ece, dwrd, fmterr}
  function automatic logic [5:0] mOut();
    logic zdv, sbdv, dfev, ecev;
    zdv  = (mPhase == P_PRE) && (mZeros == ZEROBITS);
    sbdv = (mPhase == P_DATA) || (mPhase == P_ECC);
    dfev = (mPhase == P_DATA);
    ecev = (mPhase == P_ECC);
    return {zdv, sbdv, dfev, ecev, mWord, mErr};
  endfunction

  function automatic logic [5:0] dutOut();
    return {bus.rpZD, bus.rpSBD, bus.rpDFE, bus.rpECE, bus.rpDWRD, bus.rpFMTERR};
  endfunction

  task automatic pushModel();
    logic [5:0] v;
    v = mOut();
    if (v != mLast) begin
      exp_q.push_back(v);
      mLast = v;
    end
  endtask

  task automatic mBit(input bit b);
    if (!mDmd) return;
    mWord = 1'b0;
    case (mPhase)
      P_PRE: begin
        if (!b) mZeros = (mZeros < ZEROBITS) ? mZeros + 1 : ZEROBITS;
        else if (mZeros == ZEROBITS) begin mPhase = P_DATA; mBits = 0; end
        else mZeros = 0;
      end
      P_DATA: begin
        mBits++;
        if (mBits % 16 == 0) mWord = 1'b1;
        if (mBits == DATABITS) begin
          mPhase = ECC_EN ? P_ECC : P_DONE;
          mBits = 0;
        end
      end
      P_ECC: begin
        mBits++;
        if (mBits == ECCBITS) mPhase = P_DONE;
      end
      default: ;
    endcase
  endtask

  task automatic mSync();
    if (!mDmd) return;
    if (mPhase == P_DATA || mPhase == P_ECC) mErr = 1'b1;
    mPhase = P_PRE;
    mZeros = 0;
    mWord = 1'b0;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Monitor: every change of the DUT output vector must match the next expected vector.
  logic [5:0] seen = 6'b0;
  bit         monEn = 1'b0;
  int         dwrdPulses = 0;

  always @(negedge clk) begin : monitor
    logic [5:0] cur;
    logic [5:0] want;
    cur = dutOut();
    if (monEn && cur != seen) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_change got=%b want=none", cur);
      end else begin
        want = exp_q.pop_front();
        if (cur !== want) begin
          failures++;
          $display("FAIL output_seq got=%b want=%b", cur, want);
        end
      end
      if (cur[1] && !seen[1]) dwrdPulses++;
      seen = cur;
    end
  end

  task automatic doBit(input bit b);
    @(negedge clk);
    bus.rpDRDD = b;
    bus.rpDCLK = 1'b1;
    mBit(b);
    pushModel();
    @(negedge clk);
    bus.rpDCLK = 1'b0;
    repeat ($urandom_range(0, 1)) @(negedge clk);
  endtask

  task automatic doSync(input bit useSck, input bit withBit);
    @(negedge clk);
    if (useSck) bus.rpDSCK = 1'b1;
    else bus.rpDIND = 1'b1;
    if (withBit) begin
      bus.rpDRDD = 1'($urandom_range(0, 1));
      bus.rpDCLK = 1'b1;
    end
    mSync();
    pushModel();
    @(negedge clk);
    bus.rpDSCK = 1'b0;
    bus.rpDIND = 1'b0;
    bus.rpDCLK = 1'b0;
  endtask

  task automatic doDmd(input bit v);
    @(negedge clk);
    bus.rpDMD = v;
    mDmd = v;
    if (!v) begin
      mPhase = P_IDLE;
      mWord = 1'b0;
    end
    pushModel();
    @(negedge clk);
  endtask

  task automatic doRst(input bit viaClr, input string name);
    @(negedge clk);
    if (viaClr) bus.rpDRVCLR = 1'b1;
    else rst = 1'b0;
    mPhase = P_IDLE;
    mWord = 1'b0;
    mErr = 1'b0;
    pushModel();
    @(negedge clk);
    check({name, "_outputs"}, 32'(dutOut()), 32'd0);
    check({name, "_state"}, 32'(dbgState), 32'd0);
    bus.rpDRVCLR = 1'b0;
    rst = 1'b1;
  endtask

  task automatic settle();
    repeat (2) @(negedge clk);
  endtask

  task automatic syncPreamble(input bit useSck);
    doSync(useSck, 1'b0);
    repeat (ZEROBITS) doBit(1'b0);
    doBit(1'b1);
  endtask

  initial begin
    bus.rpDRVCLR = 1'b0;
    bus.rpDMD = 1'b0;
    bus.rpDCLK = 1'b0;
    bus.rpDIND = 1'b0;
    bus.rpDSCK = 1'b0;
    bus.rpDRDD = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(dutOut()), 32'd0);
    check("reset_state", 32'(dbgState), 32'd0);
    seen = dutOut();
    monEn = 1'b1;
    rst = 1'b1;
    doDmd(1'b1);

    // Full sector: 16-zero preamble, sync, data, ECC (when built), DONE.
    doSync(1'b0, 1'b0);
    repeat (ZEROBITS) doBit(1'b0);
    settle();
    check("zd_after_preamble", 32'({bus.rpZD, bus.rpSBD, bus.rpDFE}), 32'b100);
    doBit(1'b1);
    settle();
    check("sync_outputs", 32'({bus.rpZD, bus.rpSBD, bus.rpDFE}), 32'b011);
    dwrdPulses = 0;
    for (int i = 0; i < DATABITS; i++) doBit(1'($urandom_range(0, 1)));
    settle();
    check("ece_after_data", 32'({bus.rpDFE, bus.rpECE}), ECC_EN ? 32'b01 : 32'b00);
    if (ECC_EN) for (int i = 0; i < ECCBITS; i++) doBit(1'($urandom_range(0, 1)));
    repeat (2) doBit(1'b0);
    settle();
    check("dwrd_pulses", 32'(dwrdPulses), 32'd288);
    check("done_outputs", 32'(dutOut()), 32'd0);

    // A 1 inside a short zero run resets the preamble; only the second 1 syncs.
    doSync(1'b1, 1'b0);
    repeat (10) doBit(1'b0);
    doBit(1'b1);
    settle();
    check("early_one_no_sync", 32'(bus.rpSBD), 32'd0);
    repeat (ZEROBITS) doBit(1'b0);
    doBit(1'b1);
    settle();
    check("second_one_sync", 32'(bus.rpSBD), 32'd1);

    // Sector edge at data bit 100 flags a format error; it survives DMD drop.
    repeat (99) doBit(1'($urandom_range(0, 1)));
    doSync(1'b1, 1'b1);
    settle();
    check("fmterr_set", 32'({bus.rpFMTERR, bus.rpSBD}), 32'b10);
    repeat (5) doBit(1'b0);
    doDmd(1'b0);
    settle();
    check("fmterr_through_dmd", 32'(dutOut()), 32'b000001);
    doDmd(1'b1);
    doRst(1'b1, "drvclr");

    // Saturated preamble still syncs on the first 1.
    doSync(1'b0, 1'b0);
    repeat (ZEROBITS + 4) doBit(1'b0);
    doBit(1'b1);
    settle();
    check("saturated_sync", 32'(bus.rpSBD), 32'd1);

    // Reset mid-sector (in ECC when built) abandons it without an error.
    repeat (ECC_EN ? DATABITS + 10 : 200) doBit(1'($urandom_range(0, 1)));
    doRst(1'b0, "rst_mid_sector");
    settle();
    check("no_err_after_rst", 32'(bus.rpFMTERR), 32'd0);

    // Random traffic over preamble, short data runs, errors and mode drops.
    doDmd(1'b1);
    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 75) doBit($urandom_range(0, 7) == 0);
      else if (r < 85) doSync(1'($urandom_range(0, 1)), 1'b0);
      else if (r < 91) doSync(1'($urandom_range(0, 1)), 1'b1);
      else if (r < 97) doDmd(!mDmd);
      else doRst(1'($urandom_range(0, 1)), "rand_reset");
    end

    repeat (6) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rp_diag_seq.md
RP_DIAG_SEQ -- requirements
Module: rp_diag_seq

Interface
REQ-001 Parameter DATABITS, default 4608, number of bit clocks in the data field (128 words x 36 bits).
REQ-002 Parameter ECCBITS, default 32, number of bit clocks in the ECC field.
REQ-003 Parameter ZEROBITS, default 16, consecutive zero bits required before the preamble is valid.
REQ-004 clk  input  1  clock; the only clock in the block.
REQ-005 rst  input  1  synchronous reset, active-low.
REQ-006 rpDRVCLR  input  1  drive clear, active-high, synchronous.
REQ-007 rpDMD  input  1  diagnostic mode enable.
REQ-008 rpDCLK  input  1  diagnostic bit clock, level; its rising edge advances one bit.
REQ-009 rpDIND  input  1  diagnostic index pulse, level.
REQ-010 rpDSCK  input  1  diagnostic sector clock, level.
REQ-011 rpDRDD  input  1  diagnostic read data bit.
REQ-012 rpZD  output  1  zero detect; preamble is valid.
REQ-013 rpSBD  output  1  sync byte detected.
REQ-014 rpDFE  output  1  data field envelope.
REQ-015 rpECE  output  1  ECC field envelope.
REQ-016 rpDWRD  output  1  word-boundary strobe, one bit time per 16 data bits.
REQ-017 rpFMTERR  output  1  sticky format error.

Function
REQ-018 Each of rpDCLK, rpDIND and rpDSCK shall be registered once, and rising-edge detected as current & ~previous.
REQ-019 All outputs shall be registered and shall change on the clk edge after the detected edge cycle (two-clk latency from the input being sampled high).
REQ-020 States shall be IDLE, PRE, DATA, ECC and DONE; all outputs are 0 in IDLE.
REQ-021 IDLE -> PRE shall occur on an rpDIND or rpDSCK edge while rpDMD=1, clearing the bit counter.
REQ-022 In PRE, on each bit edge:
  - rpDRDD=0 shall increment the zero count, saturating at ZEROBITS.
  - rpZD shall assert when the count reaches ZEROBITS.
REQ-023 In PRE, rpDRDD=1 with count<ZEROBITS shall clear the count and rpZD, with no state change.
REQ-024 In PRE, rpDRDD=1 with count=ZEROBITS shall assert rpSBD, deassert rpZD and enter DATA with the counter cleared.
REQ-025 In DATA:
  - rpDFE shall be 1.
  - The counter shall increment per bit edge.
  - rpDWRD shall be 1 for the bit time following every 16th data bit.
  - After bit DATABITS the block shall enter ECC with the counter cleared.
REQ-026 In ECC, rpECE shall be 1 and rpDFE 0; after ECCBITS bit edges the block shall enter DONE.
REQ-027 rpSBD shall stay 1 from sync through DATA and ECC, and shall clear on entry to DONE.
REQ-028 DONE shall behave as IDLE except that an rpDIND/rpDSCK edge restarts PRE.
REQ-029 An rpDIND/rpDSCK edge in PRE shall restart PRE with the zero count cleared.
REQ-030 An rpDIND/rpDSCK edge in DATA/ECC shall set rpFMTERR and restart PRE.
REQ-031 An index or sector edge coincident with a bit edge shall take priority, and the bit shall be discarded.
REQ-032 rpDMD=0 shall force IDLE and zero all outputs except rpFMTERR on the next clk.
REQ-033 The bit counter shall be 13 bits wide; a parameter value exceeding 8191 is illegal.

Reset
REQ-034 rst=0 at a clk edge shall force IDLE, clear all counters and edge registers, and drive every output to 0.
REQ-035 rpDRVCLR=1 shall have the same effect as rst, including clearing rpFMTERR.
REQ-036 rpDMD=0 shall not clear rpFMTERR.
REQ-037 Reset asserted mid-sector shall abandon the sector with no error flagged.

Configuration
REQ-038 With RPDIAG_ECC_EN defined, the ECC state shall exist as specified.
REQ-039 With RPDIAG_ECC_EN undefined, DATA shall go directly to DONE after DATABITS bits, and rpECE shall be tied to 0.

Verification
REQ-040 rpDMD=1, rpDIND edge, 16 zero bits -> rpZD=1 after the 16th bit edge, with rpSBD=0 and rpDFE=0.
REQ-041 Then 1 bit of rpDRDD=1 -> rpZD=0, rpSBD=1, rpDFE=1; rpDWRD pulses after data bits 16, 32, ..., 4608 (288 pulses).
REQ-042 After 4608 data bits -> rpDFE=0 and rpECE=1 for exactly 32 bit edges, then DONE with all outputs 0 (with RPDIAG_ECC_EN); without the macro, rpECE never asserts.
REQ-043 Preamble of 10 zeros, a 1, then 16 zeros, then a 1 -> rpSBD asserts only on the second 1.
REQ-044 rpDSCK edge at data bit 100 -> rpFMTERR=1 and PRE restarts; rpFMTERR stays 1 through rpDMD=0 and clears only on rpDRVCLR=1 or rst=0.
REQ-045 rst=0 for one clk during ECC -> all outputs 0 on the next clk and state IDLE.
